// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU. The fetch unit, decoder and
// control block all use these opcode values and the fetch state encoding.
package cpu_pkg;

  // Opcodes the front end has to recognise
  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_JZ   = 8'hD0;
  localparam logic [7:0] OP_JGE  = 8'hD2;
  localparam logic [7:0] OP_JMP  = 8'hD4;
  localparam logic [7:0] OP_LOAD = 8'hD6;

  // Every opcode whose high nibble is this value carries an operand byte
  localparam logic [3:0] TWO_BYTE_PREFIX = 4'hD;

  typedef enum logic [1:0] {
    FS_IDLE      = 2'd0,
    FS_FETCH_OP  = 2'd1,
    FS_FETCH_ARG = 2'd2,
    FS_EXEC      = 2'd3
  } fetch_state_e;

  // Undefined 0xDx codes still count as two-byte so the PC stays aligned
  function automatic logic isTwoByte(input logic [7:0] op);
    return op[7:4] == TWO_BYTE_PREFIX;
  endfunction

  // Only these opcodes may redirect the PC
  function automatic logic isJump(input logic [7:0] op);
    return (op == OP_JZ) || (op == OP_JGE) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the accumulator CPU: owns the PC, reads opcode and operand
// bytes over the req/ack memory port, and holds IR/operand for the decoder
// until the control block reports the instruction done.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [7:0]        ir_out,
  output logic [7:0]        operand,
  output logic              ir_valid,
  input  logic              exec_done,
  input  logic              branch_taken,
  output logic [ADDR_W-1:0] pc
);

  fetch_state_e      r_state;
  fetch_state_e      w_nextState;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_ir;
  logic [7:0]        r_operand;
  logic              r_memRd;
  logic              r_irValid;
  logic              w_memRdNext;
  logic              w_irValidNext;
  logic [ADDR_W-1:0] w_branchTarget;
  logic [ADDR_W-1:0] w_pcInc;

  assign w_branchTarget = ADDR_W'(r_operand);
  assign w_pcInc        = r_pc + ADDR_W'(1);

  // State register; reset parks the unit at an instruction boundary
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= FS_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic plus the values the Moore outputs take in that state
  always_comb begin
    w_nextState   = r_state;
    w_memRdNext   = 1'b0;
    w_irValidNext = 1'b0;
    unique case (r_state)
      FS_IDLE: begin
        if (run) begin
          w_nextState = FS_FETCH_OP;
        end
      end
      FS_FETCH_OP: begin
        if (mem_ack) begin
          w_nextState = isTwoByte(mem_rdata) ? FS_FETCH_ARG : FS_EXEC;
        end
      end
      FS_FETCH_ARG: begin
        if (mem_ack) begin
          w_nextState = FS_EXEC;
        end
      end
      FS_EXEC: begin
        if (exec_done) begin
          w_nextState = run ? FS_FETCH_OP : FS_IDLE;
        end
      end
      default: w_nextState = FS_IDLE;
    endcase
    w_memRdNext   = (w_nextState == FS_FETCH_OP) || (w_nextState == FS_FETCH_ARG);
    w_irValidNext = (w_nextState == FS_EXEC);
  end

  // Outputs are registered from the next state so they change with the state itself
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_memRd   <= 1'b0;
      r_irValid <= 1'b0;
    end else begin
      r_memRd   <= w_memRdNext;
      r_irValid <= w_irValidNext;
    end
  end

  // PC, IR and operand: load on acks during fetch, redirect on a taken jump
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc      <= PC_RESET;
      r_ir      <= OP_NOP;
      r_operand <= 8'h00;
    end else begin
      unique case (r_state)
        FS_FETCH_OP: begin
          if (mem_ack) begin
            r_ir <= mem_rdata;
            r_pc <= w_pcInc;
          end
        end
        FS_FETCH_ARG: begin
          if (mem_ack) begin
            r_operand <= mem_rdata;
            r_pc      <= w_pcInc;
          end
        end
        FS_EXEC: begin
          if (exec_done && branch_taken && isJump(r_ir)) begin
            r_pc <= w_branchTarget;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_addr = r_pc;
  assign pc       = r_pc;
  assign mem_rd   = r_memRd;
  assign ir_valid = r_irValid;
  assign ir_out   = r_ir;
  assign operand  = r_operand;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios followed by a randomized
// program run against an instruction-level reference model.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       run = 1'b0;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_ack = 1'b0;
  logic [7:0] ir_out;
  logic [7:0] operand;
  logic       ir_valid;
  logic       exec_done = 1'b0;
  logic       branch_taken = 1'b0;
  logic [7:0] pc;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [256];
  bit         respEnable = 1'b0;
  logic       ackForce = 1'b0;
  logic [7:0] staleData = 8'h00;
  int         ackLatency = 0;
  int         waitCnt = 0;

  instr_fetch_unit #(.ADDR_W(8), .PC_RESET(8'h00)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .run          (run),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .ir_out       (ir_out),
    .operand      (operand),
    .ir_valid     (ir_valid),
    .exec_done    (exec_done),
    .branch_taken (branch_taken),
    .pc           (pc)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Memory responder: acks a held request after ackLatency wait cycles
  always @(negedge clk) begin
    if (respEnable) begin
      if (mem_rd) begin
        if (waitCnt >= ackLatency) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          waitCnt   = 0;
        end else begin
          mem_ack = 1'b0;
          waitCnt++;
        end
      end else begin
        mem_ack = 1'b0;
        waitCnt = 0;
      end
    end else begin
      mem_ack   = ackForce;
      mem_rdata = staleData;
      waitCnt   = 0;
    end
  end

  // Watchdog so a stuck design can never hang the run
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic isJumpOp(input logic [7:0] op);
    return (op == 8'hD0) || (op == 8'hD2) || (op == 8'hD4);
  endfunction

  // Waits (bounded) for ir_valid, reporting how many clock edges it took
  task automatic waitValid(output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (ir_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One-cycle exec_done pulse from the control block
  task automatic pulseExec(input logic taken);
    exec_done    = 1'b1;
    branch_taken = taken;
    @(posedge clk);
    #1;
    exec_done    = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h50; mem[8'h01] = 8'hD4; mem[8'h02] = 8'h3C;
    mem[8'h3C] = 8'hD0; mem[8'h3D] = 8'h10; mem[8'h3E] = 8'h50;
    mem[8'h3F] = 8'hD4; mem[8'h40] = 8'hFF; mem[8'hFF] = 8'h07;
    reset_n = 1'b0; run = 1'b1; respEnable = 1'b0; ackForce = 1'b1; staleData = 8'hD4;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pc !== 8'h00) begin failures++; $display("[TB] FAIL reset_pc: got %h expected 00", pc); end
    checks++; if (ir_out !== 8'h00) begin failures++; $display("[TB] FAIL reset_ir: got %h expected 00", ir_out); end
    checks++; if (operand !== 8'h00) begin failures++; $display("[TB] FAIL reset_operand: got %h expected 00", operand); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", ir_valid); end
    checks++; if (mem_rd !== 1'b0) begin failures++; $display("[TB] FAIL reset_memrd: got %b expected 0", mem_rd); end
  endtask

  task automatic test_one_byte;
    bit ok; int cycles;
    ackForce = 1'b0; ackLatency = 0; respEnable = 1'b1;
    reset_n = 1'b1;
    waitValid(ok, cycles);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL one_byte_timeout: got no ir_valid expected ir_valid"); end
    checks++; if (cycles !== 2) begin failures++; $display("[TB] FAIL one_byte_latency: got %0d expected 2", cycles); end
    checks++; if (ir_out !== 8'h50) begin failures++; $display("[TB] FAIL one_byte_ir: got %h expected 50", ir_out); end
    checks++; if (pc !== 8'h01) begin failures++; $display("[TB] FAIL one_byte_pc: got %h expected 01", pc); end
    pulseExec(1'b0);
    checks++; if ({ir_valid, mem_rd, mem_addr} !== {1'b0, 1'b1, 8'h01}) begin failures++;
      $display("[TB] FAIL one_byte_next_fetch: got valid=%b rd=%b addr=%h expected 0 1 01", ir_valid, mem_rd, mem_addr); end
  endtask

  task automatic test_two_byte_jump;
    bit ok; int cycles;
    waitValid(ok, cycles);
    checks++; if (!ok || cycles !== 2) begin failures++; $display("[TB] FAIL jmp_latency: got ok=%b cycles=%0d expected 1 2", ok, cycles); end
    checks++; if ({ir_out, operand, pc} !== {8'hD4, 8'h3C, 8'h03}) begin failures++;
      $display("[TB] FAIL jmp_fetch: got ir=%h op=%h pc=%h expected D4 3C 03", ir_out, operand, pc); end
    pulseExec(1'b1);
    checks++; if ({pc, mem_rd, mem_addr} !== {8'h3C, 1'b1, 8'h3C}) begin failures++;
      $display("[TB] FAIL jmp_taken: got pc=%h rd=%b addr=%h expected 3C 1 3C", pc, mem_rd, mem_addr); end
  endtask

  task automatic test_not_taken;
    bit ok; int cycles;
    waitValid(ok, cycles);
    checks++; if (!ok || cycles !== 2) begin failures++; $display("[TB] FAIL jz_latency: got ok=%b cycles=%0d expected 1 2", ok, cycles); end
    checks++; if ({ir_out, operand, pc} !== {8'hD0, 8'h10, 8'h3E}) begin failures++;
      $display("[TB] FAIL jz_fetch: got ir=%h op=%h pc=%h expected D0 10 3E", ir_out, operand, pc); end
    pulseExec(1'b0);
    checks++; if (pc !== 8'h3E) begin failures++; $display("[TB] FAIL jz_not_taken_pc: got %h expected 3E", pc); end
    waitValid(ok, cycles);
    checks++; if (!ok || cycles !== 1) begin failures++; $display("[TB] FAIL nonjump_latency: got ok=%b cycles=%0d expected 1 1", ok, cycles); end
    checks++; if ({ir_out, operand, pc} !== {8'h50, 8'h10, 8'h3F}) begin failures++;
      $display("[TB] FAIL nonjump_fetch: got ir=%h op=%h pc=%h expected 50 10 3F", ir_out, operand, pc); end
    pulseExec(1'b1);
    checks++; if (pc !== 8'h3F) begin failures++; $display("[TB] FAIL nonjump_taken_ignored: got %h expected 3F", pc); end
  endtask

  task automatic test_wait_wrap;
    bit ok; int cycles;
    waitValid(ok, cycles);
    checks++; if (!ok || pc !== 8'h41) begin failures++; $display("[TB] FAIL jmp_ff_fetch: got ok=%b pc=%h expected 1 41", ok, pc); end
    pulseExec(1'b1);
    checks++; if (pc !== 8'hFF) begin failures++; $display("[TB] FAIL jmp_ff_pc: got %h expected FF", pc); end
    ackLatency = 3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++; if ({mem_rd, mem_addr, ir_valid} !== {1'b1, 8'hFF, 1'b0}) begin failures++;
        $display("[TB] FAIL wait_hold_%0d: got rd=%b addr=%h valid=%b expected 1 FF 0", i, mem_rd, mem_addr, ir_valid); end
    end
    waitValid(ok, cycles);
    checks++; if (!ok || cycles !== 1) begin failures++; $display("[TB] FAIL wait_latency: got ok=%b cycles=%0d expected 1 1", ok, cycles); end
    checks++; if ({ir_out, pc} !== {8'h07, 8'h00}) begin failures++;
      $display("[TB] FAIL wrap: got ir=%h pc=%h expected 07 00", ir_out, pc); end
    ackLatency = 2;
    mem[8'h00] = 8'hD6; mem[8'h01] = 8'hAB; mem[8'h02] = 8'h50;
    pulseExec(1'b1);
    checks++; if (pc !== 8'h00) begin failures++; $display("[TB] FAIL wrap_nonjump_pc: got %h expected 00", pc); end
  endtask

  task automatic test_run_stop_reset;
    bit ok; bit found; int cycles;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (mem_rd === 1'b1 && mem_addr === 8'h01) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin failures++; $display("[TB] FAIL reach_fetch_arg: got no operand request expected addr 01"); end
    run = 1'b0;
    waitValid(ok, cycles);
    checks++; if (!ok || {ir_out, operand, pc} !== {8'hD6, 8'hAB, 8'h02}) begin failures++;
      $display("[TB] FAIL stop_completes: got ok=%b ir=%h op=%h pc=%h expected 1 D6 AB 02", ok, ir_out, operand, pc); end
    pulseExec(1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({ir_valid, mem_rd, pc} !== {1'b0, 1'b0, 8'h02}) begin failures++;
      $display("[TB] FAIL parked_idle: got valid=%b rd=%b pc=%h expected 0 0 02", ir_valid, mem_rd, pc); end
    ackLatency = 0;
    run = 1'b1;
    waitValid(ok, cycles);
    checks++; if (!ok || {ir_out, pc} !== {8'h50, 8'h03}) begin failures++;
      $display("[TB] FAIL restart: got ok=%b ir=%h pc=%h expected 1 50 03", ok, ir_out, pc); end
    respEnable = 1'b0; ackForce = 1'b1; staleData = 8'hD4;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if ({pc, ir_out, operand, ir_valid, mem_rd} !== {8'h00, 8'h00, 8'h00, 1'b0, 1'b0}) begin failures++;
      $display("[TB] FAIL mid_exec_reset: got pc=%h ir=%h op=%h valid=%b rd=%b expected 00 00 00 0 0", pc, ir_out, operand, ir_valid, mem_rd); end
    run = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({pc, ir_out, ir_valid, mem_rd} !== {8'h00, 8'h00, 1'b0, 1'b0}) begin failures++;
      $display("[TB] FAIL stale_ack: got pc=%h ir=%h valid=%b rd=%b expected 00 00 0 0", pc, ir_out, ir_valid, mem_rd); end
    ackForce = 1'b0;
  endtask

  task automatic test_random;
    bit ok; int cycles; int lat; int expCycles; bit two; logic taken;
    logic [7:0] modelPc; logic [7:0] modelOperand; logic [7:0] modelIr;
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 2) == 0) mem[i] = {4'hD, 4'($urandom_range(0, 15))};
      else mem[i] = 8'($urandom_range(0, 255));
    end
    modelPc = 8'h00;
    modelOperand = 8'h00;
    respEnable = 1'b1;
    for (int n = 0; n < 40; n++) begin
      lat = $urandom_range(0, 2);
      ackLatency = lat;
      if (n == 0) run = 1'b1;
      modelIr = mem[modelPc];
      two = (modelIr[7:4] == 4'hD);
      modelPc = modelPc + 8'd1;
      if (two) begin
        modelOperand = mem[modelPc];
        modelPc = modelPc + 8'd1;
      end
      expCycles = (n == 0 ? 1 : 0) + (lat + 1) * (two ? 2 : 1);
      waitValid(ok, cycles);
      checks++; if (!ok || cycles !== expCycles) begin failures++;
        $display("[TB] FAIL rand_latency_%0d: got ok=%b cycles=%0d expected 1 %0d", n, ok, cycles, expCycles); end
      checks++; if ({ir_out, operand, pc} !== {modelIr, modelOperand, modelPc}) begin failures++;
        $display("[TB] FAIL rand_fetch_%0d: got ir=%h op=%h pc=%h expected %h %h %h", n, ir_out, operand, pc, modelIr, modelOperand, modelPc); end
      taken = 1'($urandom_range(0, 1));
      pulseExec(taken);
      if (taken && isJumpOp(modelIr)) modelPc = modelOperand;
      checks++; if (pc !== modelPc) begin failures++;
        $display("[TB] FAIL rand_exec_pc_%0d: got %h expected %h", n, pc, modelPc); end
    end
  endtask

  // Scenario sequence
  initial begin
    $display("[TB] starting instr_fetch_unit bench");
    test_reset();
    test_one_byte();
    test_two_byte_jump();
    test_not_taken();
    test_wait_wrap();
    test_run_stop_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
